// File: rtl/order_xlate_param_if.sv
// Order-translation stream bundle: order in, (memory address, bank) out, with busy status.
interface order_xlate_param_if #(
    parameter int D_W     = 16,
    parameter int DIGIT_W = 4,
    parameter int MA_W    = 12
);
    logic [D_W-1:0]     in_order;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [MA_W-1:0]    out_ma;
    logic [DIGIT_W-1:0] out_bank;
    logic               out_valid;
    logic               out_last;
    logic               out_ready;
    logic               busy;

    modport master (
        output in_order, in_valid, in_last, out_ready,
        input  in_ready, out_ma, out_bank, out_valid, out_last, busy
    );

    modport slave (
        input  in_order, in_valid, in_last, out_ready,
        output in_ready, out_ma, out_bank, out_valid, out_last, busy
    );
endinterface

// File: rtl/order_xlate_param.sv
// Order -> (memory address, bank) translator: pipelined digit-sum modulo RADIX, one item per cycle.
// Optional output backpressure is enabled by defining ORDER_XLATE_BACKPRESSURE_EN.
module order_xlate_param #(
    parameter int D_W        = 16,
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int RADIX      = 16,
    parameter int DELTA      = 4,
    parameter int MA_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    order_xlate_param_if.slave bus
);
    localparam int NS = NUM_DIGITS - 1;
    localparam logic [DIGIT_W:0] RAD = (DIGIT_W+1)'(RADIX);

    // Operands may exceed RADIX-1 (raw digits), so reduce the full sum, not each term.
    function automatic logic [DIGIT_W-1:0] madd(input logic [DIGIT_W-1:0] a, input logic [DIGIT_W-1:0] b);
        logic [DIGIT_W:0] s;
        s = ({1'b0, a} + {1'b0, b}) % RAD;
        return s[DIGIT_W-1:0];
    endfunction

    logic          w_adv;
    logic [NS-1:0] w_stg_vld;

`ifdef ORDER_XLATE_BACKPRESSURE_EN
    assign w_adv = !bus.out_valid || bus.out_ready;
`else
    assign w_adv = 1'b1;
`endif
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < NS; k++) begin : g_stg
        localparam int RW = (NS - 1 - k) * DIGIT_W;

        logic [DIGIT_W-1:0] w_sum, r_sum;
        logic [MA_W-1:0]    w_ma, r_ma;
        logic               w_vld, w_last, r_vld, r_last;

        if (k == 0) begin : g_src
            assign w_sum  = madd(bus.in_order[0 +: DIGIT_W], bus.in_order[DIGIT_W +: DIGIT_W]);
            assign w_ma   = MA_W'(bus.in_order >> DELTA);
            assign w_vld  = bus.in_valid;
            assign w_last = bus.in_valid && bus.in_last;
        end else begin : g_src
            assign w_sum  = madd(g_stg[k-1].r_sum, g_stg[k-1].g_rem.r_rem[DIGIT_W-1:0]);
            assign w_ma   = g_stg[k-1].r_ma;
            assign w_vld  = g_stg[k-1].r_vld;
            assign w_last = g_stg[k-1].r_last;
        end

        // Invalid slots carry zero data so the output register is zero whenever it is empty.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
                r_sum  <= '0;
                r_ma   <= '0;
            end else if (w_adv) begin
                r_vld  <= w_vld;
                r_last <= w_vld && w_last;
                r_sum  <= w_vld ? w_sum : '0;
                r_ma   <= w_vld ? w_ma : '0;
            end
        end

        assign w_stg_vld[k] = r_vld;

        // Digits still to be added ride alongside the partial sum, lowest first.
        if (RW > 0) begin : g_rem
            logic [RW-1:0] w_rem, r_rem;

            if (k == 0) begin : g_in
                assign w_rem = bus.in_order[2*DIGIT_W +: RW];
            end else begin : g_in
                assign w_rem = g_stg[k-1].g_rem.r_rem[DIGIT_W +: RW];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)        r_rem <= '0;
                else if (w_adv) r_rem <= w_vld ? w_rem : '0;
            end
        end
    end

    logic               r_out_valid, r_out_last;
    logic [MA_W-1:0]    r_out_ma;
    logic [DIGIT_W-1:0] r_out_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ma    <= '0;
            r_out_bank  <= '0;
        end else if (w_adv) begin
            r_out_valid <= g_stg[NS-1].r_vld;
            r_out_last  <= g_stg[NS-1].r_last;
            r_out_ma    <= g_stg[NS-1].r_ma;
            r_out_bank  <= g_stg[NS-1].r_sum;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_ma    = r_out_ma;
    assign bus.out_bank  = r_out_bank;
    assign bus.busy      = (|w_stg_vld) || r_out_valid;
endmodule

// File: tb/tb_order_xlate_param.sv
// Bench for order_xlate_param: default-radix and RADIX=12 instances share stimulus and a queue-based model.
`timescale 1ns/1ps
module tb_order_xlate_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    order_xlate_param_if ifa ();
    order_xlate_param_if ifb ();

    order_xlate_param u_dut (.clk(clk), .rst(rst), .bus(ifa.slave));
    order_xlate_param #(.RADIX(12)) u_r12 (.clk(clk), .rst(rst), .bus(ifb.slave));

`ifdef ORDER_XLATE_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    typedef struct {
        logic [15:0] ord;
        logic        last;
        int          t;
        int          s;
    } item_t;

    item_t q[$];
    int    cyc = 0, stalls = 0, npass = 0, nfail = 0, ntot = 0;
    bit    m_ovld = 1'b0, last_acc = 1'b0;

    function automatic int bank_of(input logic [15:0] o, input int r);
        int sum;
        sum = int'(o[3:0]) + int'(o[7:4]) + int'(o[11:8]) + int'(o[15:12]);
        return sum % r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_in(input logic v, input logic l, input logic [15:0] o);
        ifa.in_valid = v; ifb.in_valid = v;
        ifa.in_last  = l; ifb.in_last  = l;
        ifa.in_order = o; ifb.in_order = o;
    endtask

    task automatic set_ordy(input logic r);
        ifa.out_ready = r;
        ifb.out_ready = r;
    endtask

    task automatic chk_outs(input string nm, input logic ov, input logic ol, input logic [11:0] oma,
                            input logic [3:0] ob, input logic obusy, input int r);
        logic [11:0] ema;
        logic [3:0]  eb;
        logic        el;
        ema = '0; eb = '0; el = 1'b0;
        if (m_ovld) begin
            ema = q[0].ord[15:4];
            eb  = 4'(bank_of(q[0].ord, r));
            el  = q[0].last;
        end
        chk({nm, ".valid"}, 32'(ov), 32'(m_ovld));
        chk({nm, ".ma"}, 32'(oma), 32'(ema));
        chk({nm, ".bank"}, 32'(ob), 32'(eb));
        chk({nm, ".last"}, 32'(ol), 32'(el));
        chk({nm, ".busy"}, 32'(obusy), 32'(q.size() != 0));
    endtask

    // One clock: predict handshake, advance the model, then compare both instances.
    task automatic tick();
        bit adv;
        #1;
        adv = BP ? (!m_ovld || ifa.out_ready) : 1'b1;
        chk("a.in_ready", 32'(ifa.in_ready), 32'(adv));
        chk("b.in_ready", 32'(ifb.in_ready), 32'(adv));
        if (m_ovld && adv) void'(q.pop_front());
        if (!adv) stalls++;
        last_acc = ifa.in_valid && adv;
        if (last_acc) q.push_back('{ifa.in_order, ifa.in_last, cyc, stalls});
        @(posedge clk);
        #1;
        cyc++;
        m_ovld = (q.size() > 0) && ((cyc - q[0].t - (stalls - q[0].s)) >= 4);
        chk_outs("a", ifa.out_valid, ifa.out_last, ifa.out_ma, ifa.out_bank, ifa.busy, 16);
        chk_outs("b", ifb.out_valid, ifb.out_last, ifb.out_ma, ifb.out_bank, ifb.busy, 12);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".a_valid"}, 32'(ifa.out_valid), 32'd0);
        chk({nm, ".a_ma"}, 32'(ifa.out_ma), 32'd0);
        chk({nm, ".a_bank"}, 32'(ifa.out_bank), 32'd0);
        chk({nm, ".a_last"}, 32'(ifa.out_last), 32'd0);
        chk({nm, ".a_busy"}, 32'(ifa.busy), 32'd0);
        chk({nm, ".b_valid"}, 32'(ifb.out_valid), 32'd0);
        chk({nm, ".b_busy"}, 32'(ifb.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] ords [6];
        int idx, guard, stall_left;

        rst = 1'b1;
        set_in(1'b0, 1'b0, 16'h0);
        set_ordy(1'b1);
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset.in_ready", 32'(ifa.in_ready), 32'd1);

        // Single order: four-cycle latency and reference values.
        set_in(1'b1, 1'b0, 16'h1234);
        tick();
        set_in(1'b0, 1'b0, 16'h0);
        repeat (3) tick();
        chk("r032.valid", 32'(ifa.out_valid), 32'd1);
        chk("r032.bank", 32'(ifa.out_bank), 32'hA);
        chk("r032.ma", 32'(ifa.out_ma), 32'h123);
        tick();

        // Back-to-back extremes, last tag on the second.
        set_in(1'b1, 1'b0, 16'hFFFF);
        tick();
        set_in(1'b1, 1'b1, 16'h0000);
        tick();
        set_in(1'b0, 1'b0, 16'h0);
        repeat (2) tick();
        chk("r033.bank0", 32'(ifa.out_bank), 32'hC);
        chk("r033.ma0", 32'(ifa.out_ma), 32'hFFF);
        chk("r033.last0", 32'(ifa.out_last), 32'd0);
        tick();
        chk("r033.bank1", 32'(ifa.out_bank), 32'h0);
        chk("r033.ma1", 32'(ifa.out_ma), 32'h000);
        chk("r033.last1", 32'(ifa.out_last), 32'd1);
        tick();

        // RADIX=12 reference with digits above the radix.
        set_in(1'b1, 1'b0, 16'h00B7);
        tick();
        set_in(1'b0, 1'b0, 16'h0);
        repeat (3) tick();
        chk("r034.bank12", 32'(ifb.out_bank), 32'h6);
        chk("r034.ma12", 32'(ifb.out_ma), 32'h00B);
        chk("r034.bank16", 32'(ifa.out_bank), 32'h2);
        tick();

        // in_last without in_valid must not create an item.
        set_in(1'b0, 1'b1, 16'hBEEF);
        repeat (6) tick();

        // Six orders, output stalled 3 cycles once the first appears.
        for (int i = 0; i < 6; i++) ords[i] = 16'($urandom);
        idx = 0; guard = 0; stall_left = 3;
        while (idx < 6 && guard < 50) begin
            set_in(1'b1, idx == 5, ords[idx]);
            if (m_ovld && stall_left > 0) begin set_ordy(1'b0); stall_left--; end
            else set_ordy(1'b1);
            tick();
            if (last_acc) idx++;
            guard++;
        end
        chk("r035.accepted", 32'(idx), 32'd6);
        set_in(1'b0, 1'b0, 16'h0);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            if (m_ovld && stall_left > 0) begin set_ordy(1'b0); stall_left--; end
            else set_ordy(1'b1);
            tick();
            guard++;
        end
        chk("r035.drained", 32'(q.size()), 32'd0);
        set_ordy(1'b1);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            set_in($urandom_range(0, 9) < 7, 1'($urandom), 16'($urandom));
            set_ordy($urandom_range(0, 3) != 0);
            tick();
        end
        set_in(1'b0, 1'b0, 16'h0);
        set_ordy(1'b1);
        repeat (10) tick();

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, i == 2, 16'($urandom));
            tick();
        end
        set_in(1'b0, 1'b0, 16'h0);
        #2 rst = 1'b1;
        #1;
        chk_zero("r036");
        q.delete();
        m_ovld = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        cyc++;
        repeat (8) tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/order_xlate_param.md
ORDER_XLATE_PARAM -- requirements
Module: order_xlate_param

Interface
REQ-001 Parameter D_W, 16, order width in bits.
REQ-002 Parameter DIGIT_W, 4, digit width; the order splits into NUM_DIGITS digits, digit i = order[i*DIGIT_W +: DIGIT_W].
REQ-003 Parameter NUM_DIGITS, 4, digits summed; NUM_DIGITS*DIGIT_W SHALL be <= D_W and NUM_DIGITS SHALL be >= 2.
REQ-004 Parameter RADIX, 16, bank count; 2 <= RADIX <= 2**DIGIT_W.
REQ-005 Parameter DELTA, 4, right shift applied to the order to form the memory address.
REQ-006 Parameter MA_W, 12, memory address width; MA = (order >> DELTA) truncated to MA_W bits.
REQ-007 clk  input  1  clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 in_order  input  D_W  order index to translate.
REQ-010 in_valid  input  1  in_order/in_last valid.
REQ-011 in_last  input  1  marks final order of an AGU sequence.
REQ-012 in_ready  output  1  block accepts input this cycle.
REQ-013 out_ma  output  MA_W  memory address.
REQ-014 out_bank  output  DIGIT_W  bank index.
REQ-015 out_valid  output  1  out_ma/out_bank/out_last valid.
REQ-016 out_last  output  1  last tag, travels with its item.
REQ-017 out_ready  input  1  downstream accepts output.
REQ-018 busy  output  1  any pipeline stage holds a valid item.

Function
REQ-019 out_bank SHALL equal (sum of all NUM_DIGITS digits) mod RADIX, computed exactly for any digit value up to 2**DIGIT_W-1.
REQ-020 Summation SHALL use a chain of NUM_DIGITS-1 two-input modular-add stages, each registered; digits not yet consumed and the shifted address travel in parallel registers.
REQ-021 Latency SHALL be NUM_DIGITS cycles from input acceptance (in_valid && in_ready at a clk edge) to out_valid, absent stalls.
REQ-022 Each stage SHALL carry a valid bit and the last tag; throughput SHALL be one item per cycle when not stalled.
REQ-023 Pipeline advance enable SHALL be adv = !out_valid || out_ready; all stages shift together when adv; in_ready = adv.
REQ-024 When out_valid is 0, out_ma and out_bank SHALL be 0 and out_last 0.
REQ-025 Bubbles (in_valid=0) SHALL propagate as invalid stages; no reordering, no duplication, no loss.
REQ-026 busy = OR of all stage valid bits including the output register.
REQ-027 in_last with in_valid=0 SHALL be ignored.

Reset
REQ-028 rst high SHALL immediately clear every valid bit, data register and output to 0; busy=0, in_ready=1 after release.
REQ-029 Reset mid-stream SHALL discard all in-flight items; no item SHALL emerge after release unless newly accepted.

Configuration
REQ-030 Macro ORDER_XLATE_BACKPRESSURE_EN defined: REQ-023 applies; while out_valid && !out_ready, out_ma/out_bank/out_last SHALL remain stable and no stage SHALL advance.
REQ-031 Macro ORDER_XLATE_BACKPRESSURE_EN undefined: out_ready SHALL be ignored, adv=1 always, in_ready tied to 1, output register reloads every cycle.

Verification
REQ-032 Defaults, in_order=0x1234 accepted at cycle 0 -> cycle 4: out_valid=1, out_bank=0xA, out_ma=0x123.
REQ-033 Defaults, in_order=0xFFFF then 0x0000 back-to-back, in_last on second -> consecutive out_bank 0xC,0x0; out_ma 0xFFF,0x000; out_last 0,1.
REQ-034 RADIX=12, in_order=0x00B7 -> out_bank=0x6, out_ma=0x00B.
REQ-035 Backpressure enabled: 6 consecutive orders, out_ready low 3 cycles after first output -> outputs held stable, in_ready=0 during stall, all 6 emerge in order with correct values.
REQ-036 Three items in flight, rst pulsed 1 cycle -> all outputs 0 asynchronously, busy=0, no stale item appears within 8 cycles.
